// File: rtl/hpm_trace_buffer.sv
// HPM snapshot trace buffer: CSR-triggered counter sampling into a FIFO,
// drained by an external detector before the next monitoring window.
module hpm_trace_buffer #(
  parameter int          NUM_CNT   = 3,
  parameter int          CNT_W     = 32,
  parameter int          DEPTH     = 4,
  parameter logic [11:0] CSR_ADDR  = 12'h320,
  parameter logic [31:0] START_VAL = 32'h0000_0000,
  parameter logic [31:0] STOP_VAL  = 32'hFFFF_FFFF,
  parameter int          SEQ_W     = 8
) (
  input  logic                     clk_h,
  input  logic                     rst_h,
  input  logic                     csr_we,
  input  logic [11:0]              csr_add,
  input  logic [31:0]              csr_data,
  input  logic                     periodic,
  input  logic [15:0]              period,
  input  logic [NUM_CNT*CNT_W-1:0] hpm_in,
  output logic                     snap_valid,
  input  logic                     snap_ready,
  output logic [NUM_CNT*CNT_W-1:0] snap_data,
  output logic [SEQ_W-1:0]         snap_seq,
  input  logic                     end_detect,
  output logic                     detect_en,
  output logic                     overflow
);

  localparam int DW = NUM_CNT * CNT_W;
  localparam int EW = DW + SEQ_W;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MON   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state;
  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    head;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic [SEQ_W-1:0] seq_cnt;
  logic [15:0]      ivl_cnt;
  logic [15:0]      per_eff;

  logic trig;
  logic start;
  logic stop;
  logic in_mon;
  logic tick;
  logic push;
  logic pop;
  logic full;
  logic wr_en;
  logic flush;

  assign trig    = csr_we && (csr_add == CSR_ADDR);
  assign start   = trig && (csr_data == START_VAL);
  assign stop    = trig && (csr_data == STOP_VAL);
  assign in_mon  = (state == S_MON);
  assign per_eff = (period == 16'd0) ? 16'd1 : period;
  assign tick    = in_mon && periodic && (ivl_cnt >= per_eff - 16'd1);
  // stop and a coincident tick share the single push of this cycle
  assign push    = in_mon && (stop || tick);
  assign pop     = snap_valid && snap_ready;
  assign full    = (count == FULL_CNT);
  assign wr_en   = push && (!full || pop);
  assign flush   = (state == S_DRAIN) && end_detect;

  always_ff @(posedge clk_h or posedge rst_h) begin
    if (rst_h) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (start)      state <= S_MON;
        S_MON:   if (stop)       state <= S_DRAIN;
        S_DRAIN: if (end_detect) state <= S_IDLE;
        default:                 state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_h or posedge rst_h) begin
    if (rst_h) begin
      seq_cnt  <= '0;
      ivl_cnt  <= '0;
      overflow <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      seq_cnt  <= '0;
      ivl_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      // dropped snapshots still consume a sequence number
      if (push)           seq_cnt  <= seq_cnt + 1'b1;
      if (push && !wr_en) overflow <= 1'b1;
      if (in_mon && periodic)
        ivl_cnt <= tick ? 16'd0 : ivl_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_h or posedge rst_h) begin
    if (rst_h) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_h) begin
    if (wr_en) mem[wr_ptr] <= {seq_cnt, hpm_in};
  end

  // outputs are gated so stale storage never shows while empty
  assign head       = mem[rd_ptr];
  assign snap_valid = (count != '0);
  assign snap_data  = snap_valid ? head[DW-1:0] : '0;
  assign snap_seq   = snap_valid ? head[DW +: SEQ_W] : '0;
  assign detect_en  = (state == S_DRAIN);

endmodule
